// File: rtl/stopwatch_ctrl.sv
// ---------------------------------------------------------------------------
// stopwatch_ctrl
//
// Control front end for a seconds stopwatch. Two bouncy push buttons
// (start/pause and clear) are synchronised and debounced. Each accepted press
// becomes a one-cycle event, and those events drive a small IDLE/RUN/PAUSE
// state machine. While running, a prescaler divides the system clock down to
// a one-cycle-per-second count-enable for a downstream seconds counter.
//
// Parameters
//   FREQ     clock frequency in Hz; the prescaler period in cycles
//   DEB_CYC  cycles a synchronised key level must differ from the accepted
//            level before it is taken as the new level
//
// Ports
//   clk          in   system clock; all state changes on the rising edge
//   n_rst        in   asynchronous active-low reset
//   key_start_n  in   start/pause button, active-low, async, bouncy
//   key_clr_n    in   clear button, active-low, async, bouncy
//   tick_1hz     out  one-cycle count-enable pulse, once per second in RUN
//   clr          out  one-cycle clear pulse for the seconds counter
//   running      out  high while the controller is in RUN
// ---------------------------------------------------------------------------
module stopwatch_ctrl #(
    parameter int FREQ    = 50_000_000,
    parameter int DEB_CYC = 500_000
) (
    input  logic clk,
    input  logic n_rst,
    input  logic key_start_n,
    input  logic key_clr_n,
    output logic tick_1hz,
    output logic clr,
    output logic running
);

    // Guard against a zero-width prescaler when FREQ is 1.
    localparam int PW = (FREQ > 1) ? $clog2(FREQ) : 1;
    localparam int DW = (DEB_CYC > 0) ? $clog2(DEB_CYC + 1) : 1;

    localparam logic [PW-1:0] PCNT_MAX = PW'(FREQ - 1);
    localparam logic [DW-1:0] DEB_MAX  = DW'(DEB_CYC - 1);

    // Key index 0 is start/pause, index 1 is clear.
    localparam int K_START = 0;
    localparam int K_CLR   = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [1:0]    sync1_q, sync1_d;
    logic [1:0]    sync2_q, sync2_d;
    logic [1:0]    deb_q, deb_d;
    logic [1:0]    deb_prev_q, deb_prev_d;
    logic [DW-1:0] deb_cnt_q [2];
    logic [DW-1:0] deb_cnt_d [2];

    state_t        state_q, state_d;
    logic [PW-1:0] pcnt_q, pcnt_d;
    logic          tick_q, tick_d;
    logic          clr_q, clr_d;
    logic          running_q, running_d;

    logic [1:0]    press;
    logic          start_ev;
    logic          clr_ev;

    // -----------------------------------------------------------------------
    // Two-flop synchronisers. The raw pins are sampled as a packed pair so
    // both keys share the same structure below.
    // -----------------------------------------------------------------------
    always_comb begin
        sync1_d = {key_clr_n, key_start_n};
        sync2_d = sync1_q;
    end

    // -----------------------------------------------------------------------
    // Debouncer. The counter measures how long the synchronised level has
    // disagreed with the accepted level; any agreement restarts it. When the
    // disagreement has lasted DEB_CYC evaluations the new level is accepted
    // and the counter restarts, so the counter never needs to reach DEB_CYC.
    // -----------------------------------------------------------------------
    always_comb begin
        deb_d      = deb_q;
        deb_prev_d = deb_q;
        for (int k = 0; k < 2; k++) begin
            deb_cnt_d[k] = '0;
            if (sync2_q[k] != deb_q[k]) begin
                if (deb_cnt_q[k] == DEB_MAX) begin
                    deb_d[k]     = sync2_q[k];
                    deb_cnt_d[k] = '0;
                end else begin
                    deb_cnt_d[k] = deb_cnt_q[k] + 1'b1;
                end
            end
        end
    end

    // A press is the cycle right after the accepted level falls. Releases
    // and long holds generate nothing because only the 1->0 step qualifies.
    assign press    = deb_prev_q & ~deb_q;
    assign start_ev = press[K_START];
    assign clr_ev   = press[K_CLR];

    // -----------------------------------------------------------------------
    // Controller next-state. Clear wins over start when both arrive in the
    // same cycle. The prescaler only advances on cycles that begin and end in
    // RUN, so the edge that enters RUN (from IDLE or PAUSE) and the edge that
    // leaves it both leave pcnt untouched; that is what lets a pause preserve
    // the partial second, including a pause taken at FREQ-1.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        pcnt_d  = pcnt_q;

        if (clr_ev) begin
            state_d = IDLE;
        end else if (start_ev) begin
            case (state_q)
                IDLE:    state_d = RUN;
                RUN:     state_d = PAUSE;
                PAUSE:   state_d = RUN;
                default: state_d = IDLE;
            endcase
        end

        if (state_d == IDLE) begin
            pcnt_d = '0;
        end else if ((state_q == RUN) && (state_d == RUN)) begin
            pcnt_d = (pcnt_q == PCNT_MAX) ? '0 : pcnt_q + 1'b1;
        end

        // Any event taken while in RUN leaves RUN, so requiring RUN on both
        // sides of the edge suppresses the tick for a clear or a pause that
        // lands on the last cycle of a second, and keeps tick and clr apart.
        tick_d    = (state_q == RUN) && (state_d == RUN) && (pcnt_q == PCNT_MAX);
        clr_d     = clr_ev;
        running_d = (state_d == RUN);
    end

    // -----------------------------------------------------------------------
    // All registers. Reset puts the keys in the released state so that a key
    // held down through reset is seen as a fresh press once it has been
    // stable for the debounce time.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync1_q      <= 2'b11;
            sync2_q      <= 2'b11;
            deb_q        <= 2'b11;
            deb_prev_q   <= 2'b11;
            deb_cnt_q[0] <= '0;
            deb_cnt_q[1] <= '0;
            state_q      <= IDLE;
            pcnt_q       <= '0;
            tick_q       <= 1'b0;
            clr_q        <= 1'b0;
            running_q    <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            deb_q        <= deb_d;
            deb_prev_q   <= deb_prev_d;
            deb_cnt_q[0] <= deb_cnt_d[0];
            deb_cnt_q[1] <= deb_cnt_d[1];
            state_q      <= state_d;
            pcnt_q       <= pcnt_d;
            tick_q       <= tick_d;
            clr_q        <= clr_d;
            running_q    <= running_d;
        end
    end

    assign tick_1hz = tick_q;
    assign clr      = clr_q;
    assign running  = running_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_stopwatch_ctrl
//
// Self-checking bench for stopwatch_ctrl with FREQ=10, DEB_CYC=4. Directed
// scenarios are followed by randomised key activity. A behavioural model
// predicts tick_1hz, clr and running for every cycle.
// ---------------------------------------------------------------------------
module tb_stopwatch_ctrl;

    localparam int FREQ    = 10;
    localparam int DEB_CYC = 4;

    logic clk         = 1'b0;
    logic n_rst       = 1'b1;
    logic key_start_n = 1'b1;
    logic key_clr_n   = 1'b1;
    logic tick_1hz;
    logic clr;
    logic running;

    int vectors     = 0;
    int miscompares = 0;

    stopwatch_ctrl #(
        .FREQ    (FREQ),
        .DEB_CYC (DEB_CYC)
    ) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .key_start_n (key_start_n),
        .key_clr_n   (key_clr_n),
        .tick_1hz    (tick_1hz),
        .clr         (clr),
        .running     (running)
    );

    always #5 clk = ~clk;

    // -----------------------------------------------------------------------
    // Reference model. Key pins are kept as a history of per-edge samples.
    // The level the debouncer looks at on an edge is the pin as sampled two
    // edges earlier; a key's accepted level flips once the last DEB_CYC
    // looked-at values all disagree with it. A press is reported on the edge
    // after the accepted level falls. The stopwatch itself is kept as a mode
    // plus the number of cycles spent in the current second.
    // -----------------------------------------------------------------------
    typedef enum {M_IDLE, M_RUN, M_PAUSE} mode_t;

    logic [1:0] hist [$];
    logic [1:0] deb_m;
    logic [1:0] fell_m;
    mode_t      mode_m;
    int         phase_m;
    logic       exp_tick;
    logic       exp_clr;
    logic       exp_run;

    task automatic modelReset();
        hist.delete();
        for (int i = 0; i < DEB_CYC + 1; i++) hist.push_back(2'b11);
        deb_m    = 2'b11;
        fell_m   = 2'b00;
        mode_m   = M_IDLE;
        phase_m  = 0;
        exp_tick = 1'b0;
        exp_clr  = 1'b0;
        exp_run  = 1'b0;
    endtask

    task automatic modelStep(input logic [1:0] pins);
        logic [1:0] ev;
        logic [1:0] fell_now;
        int         n;
        bit         all_diff;

        ev       = fell_m;
        fell_now = 2'b00;
        n        = hist.size();
        for (int k = 0; k < 2; k++) begin
            all_diff = 1'b1;
            for (int i = n - DEB_CYC - 1; i <= n - 2; i++)
                if (hist[i][k] == deb_m[k]) all_diff = 1'b0;
            if (all_diff) begin
                if (deb_m[k]) fell_now[k] = 1'b1;
                deb_m[k] = ~deb_m[k];
            end
        end
        fell_m = fell_now;
        hist.push_back(pins);
        if (hist.size() > 12) void'(hist.pop_front());

        exp_clr  = ev[1];
        exp_tick = 1'b0;
        if (ev[1]) begin
            mode_m  = M_IDLE;
            phase_m = 0;
        end else if (ev[0]) begin
            mode_m = (mode_m == M_RUN) ? M_PAUSE : M_RUN;
        end else if (mode_m == M_RUN) begin
            phase_m++;
            if (phase_m == FREQ) begin
                phase_m  = 0;
                exp_tick = 1'b1;
            end
        end
        exp_run = (mode_m == M_RUN);
    endtask

    // -----------------------------------------------------------------------
    // Single comparison point: counts the vector and reports a miscompare.
    // -----------------------------------------------------------------------
    task automatic checkOutput(input string tag, input logic observed, input logic expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %b, expected %b at t=%0t", tag, observed, expected, $time);
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".tick_1hz"}, tick_1hz, exp_tick);
        checkOutput({tag, ".clr"},      clr,      exp_clr);
        checkOutput({tag, ".running"},  running,  exp_run);
    endtask

    // -----------------------------------------------------------------------
    // Holds the given pin levels for n cycles. Pins change before the rising
    // edge; outputs are sampled 1 time unit after it. Called with the clock
    // low and returns on a falling edge.
    // -----------------------------------------------------------------------
    task automatic applyStimulus(input logic s_n, input logic c_n, input int n);
        for (int i = 0; i < n; i++) begin
            key_start_n = s_n;
            key_clr_n   = c_n;
            @(posedge clk);
            if (n_rst) modelStep({c_n, s_n});
            else       modelReset();
            #1;
            checkAll("cyc");
            @(negedge clk);
        end
    endtask

    // Asserts reset between clock edges and checks that outputs clear at once.
    task automatic asyncReset(input int hold_cycles);
        #2;
        n_rst = 1'b0;
        #1;
        modelReset();
        checkAll("async_rst");
        @(negedge clk);
        applyStimulus(key_start_n, key_clr_n, hold_cycles);
        n_rst = 1'b1;
    endtask

    initial begin
        modelReset();
        #1;
        n_rst = 1'b0;
        #1;
        checkAll("reset");
        applyStimulus(1, 1, 2);
        n_rst = 1'b1;

        $display("[TB] idle with keys released");
        applyStimulus(1, 1, 100);

        $display("[TB] clean start press, run with ticks");
        applyStimulus(0, 1, 30);
        applyStimulus(1, 1, 25);

        $display("[TB] clear, then bouncing start key");
        applyStimulus(1, 0, 8);
        applyStimulus(1, 1, 10);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1, 2);
            applyStimulus(1, 1, 2);
        end
        applyStimulus(1, 1, 20);

        $display("[TB] run, pause, resume");
        applyStimulus(0, 1, 6);
        applyStimulus(1, 1, 6);
        applyStimulus(0, 1, 6);
        applyStimulus(1, 1, 20);
        applyStimulus(0, 1, 6);
        applyStimulus(1, 1, 30);

        $display("[TB] clear and start together while running");
        applyStimulus(0, 0, 8);
        applyStimulus(1, 1, 10);
        applyStimulus(0, 1, 6);
        applyStimulus(1, 1, 25);
        applyStimulus(1, 0, 6);
        applyStimulus(1, 1, 10);

        $display("[TB] pause landing on the last cycle of a second");
        applyStimulus(0, 1, 6);
        applyStimulus(1, 1, 4);
        applyStimulus(0, 1, 6);
        applyStimulus(1, 1, 10);
        applyStimulus(0, 1, 6);
        applyStimulus(1, 1, 20);
        applyStimulus(1, 0, 6);
        applyStimulus(1, 1, 10);

        $display("[TB] clear landing on the last cycle of a second");
        applyStimulus(0, 1, 6);
        applyStimulus(1, 1, 4);
        applyStimulus(1, 0, 6);
        applyStimulus(1, 1, 12);

        $display("[TB] asynchronous reset while running");
        applyStimulus(0, 1, 6);
        applyStimulus(1, 1, 15);
        asyncReset(3);
        applyStimulus(1, 1, 20);

        $display("[TB] start key held through reset");
        applyStimulus(0, 1, 2);
        asyncReset(3);
        applyStimulus(0, 1, 12);
        applyStimulus(1, 1, 15);
        applyStimulus(1, 0, 6);
        applyStimulus(1, 1, 10);

        $display("[TB] randomised key activity");
        for (int seg = 0; seg < 300; seg++) begin
            logic s_n;
            logic c_n;
            int   len;
            s_n = ($urandom_range(0, 1) == 0);
            c_n = ($urandom_range(0, 4) != 0);
            len = $urandom_range(1, 12);
            if ($urandom_range(0, 59) == 0) begin
                asyncReset($urandom_range(1, 3));
            end
            applyStimulus(s_n, c_n, len);
        end
        applyStimulus(1, 1, 20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
